// File: rtl/timer_pkg.sv
// Shared types, limits and BCD helpers for the multi-preset countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } timer_state_e;

    typedef logic [3:0] bcd_digit_t;

    // Longest preset that still fits 99:59 on the display.
    localparam int unsigned MAX_SEC  = 5999;
    // Session counter rolls over after this value.
    localparam int unsigned BCD_WRAP = 9999;

    // Four-digit BCD of a binary value; only ever called on constants.
    function automatic logic [15:0] bin_to_bcd4(input int unsigned v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Seconds to M1 M0 S1 S0; only ever called on constants.
    function automatic logic [15:0] sec_to_bcd_time(input int unsigned sec);
        int unsigned m;
        int unsigned s;
        m = sec / 60;
        s = sec % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Increment a four-digit BCD value with decimal carries.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Decrement an MM:SS BCD time by one second (seconds borrow at 60).
    function automatic logic [15:0] bcd_time_dec(input logic [15:0] t);
        bcd_digit_t m1;
        bcd_digit_t m0;
        bcd_digit_t s1;
        bcd_digit_t s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a rising-edge detector.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    // Shift the button through the synchroniser and remember the last synced level.
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and history flops, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/multi_preset_timer.sv
// Multi-preset countdown timer with pause, session counter and BCD display outputs.
// Optional feature: define TIMER_AUTO_RELOAD_EN to restart the last preset one cycle after
// a session completes; otherwise the timer waits in DONE for a preset press.
// Remaining time is held directly as MM:SS BCD so the display needs no divider.
module multi_preset_timer
    import timer_pkg::*;
#(
    parameter int unsigned                CLK_HZ     = 125000000,
    parameter int unsigned                N_PRESET   = 4,
    parameter logic [16*N_PRESET-1:0]     PRESET_SEC = {16'd3000, 16'd1500, 16'd600, 16'd300}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_PRESET-1:0] btn,
    input  logic                pause_btn,
    output logic [15:0]         bcd_time,
    output logic [15:0]         bcd_count,
    output logic                running,
    output logic                done,
    output logic                dat_vld
);

    localparam int unsigned        DivW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DivW-1:0]    DivLast     = DivW'(CLK_HZ - 1);
    localparam logic [15:0]        RemOne      = 16'h0001;
    localparam logic [15:0]        BcdWrapCode = bin_to_bcd4(BCD_WRAP);

    if (N_PRESET < 1 || N_PRESET > 8) begin : g_bad_n_preset
        $error("multi_preset_timer: N_PRESET must be in 1..8");
    end

    // Preset durations converted to MM:SS BCD at elaboration; unused slots read zero.
    logic [15:0] preset_bcd [8];
    for (genvar g = 0; g < 8; g++) begin : g_preset
        if (g < N_PRESET) begin : g_used
            localparam int unsigned Sec = int'(PRESET_SEC[16*g +: 16]);
            if (Sec == 0 || Sec > MAX_SEC) begin : g_bad_sec
                $error("multi_preset_timer: PRESET_SEC entry out of range 1..5999");
            end
            assign preset_bcd[g] = sec_to_bcd_time(Sec);
        end else begin : g_unused
            assign preset_bcd[g] = '0;
        end
    end

    logic [N_PRESET-1:0] btn_rise;
    logic                pause_rise;

    for (genvar g = 0; g < N_PRESET; g++) begin : g_btn_sync
        btn_sync_edge u_btn_sync (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .btn_i  (btn[g]),
            .rise_o (btn_rise[g])
        );
    end

    btn_sync_edge u_pause_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_i  (pause_btn),
        .rise_o (pause_rise)
    );

    timer_state_e    state_q, state_d;
    logic [15:0]     rem_q, rem_d;
    logic [DivW-1:0] div_q, div_d;
    logic [15:0]     sess_q, sess_d;
    logic [2:0]      last_q, last_d;
    logic [15:0]     bcd_time_q, bcd_time_d;
    logic [15:0]     bcd_count_q, bcd_count_d;
    logic            done_q, done_d;
    logic            dat_vld_q, dat_vld_d;

    logic            preset_hit;
    logic [2:0]      preset_idx;
    logic            tick;

    // Pick the highest-index preset edge seen this cycle.
    always_comb begin
        preset_hit = 1'b0;
        preset_idx = '0;
        for (int i = 0; i < N_PRESET; i++) begin
            if (btn_rise[i]) begin
                preset_hit = 1'b1;
                preset_idx = 3'(i);
            end
        end
    end

    assign tick = (state_q == StRun) && (div_q == DivLast);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a preset edge overrides everything, including a same-cycle pause.
    always_comb begin
        state_d = state_q;
        if (preset_hit) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    // Completion wins over a pause landing on the final tick.
                    if (tick && rem_q == RemOne) begin
                        state_d = StDone;
                    end else if (pause_rise) begin
                        state_d = StPause;
                    end
                end
                StPause: begin
                    if (pause_rise) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
`ifdef TIMER_AUTO_RELOAD_EN
                    state_d = StRun;
`endif
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Countdown, divider, session counter and display next-state.
    always_comb begin
        rem_d  = rem_q;
        div_d  = div_q;
        sess_d = sess_q;
        last_d = last_q;
        done_d = 1'b0;
        if (preset_hit) begin
            rem_d  = preset_bcd[preset_idx];
            div_d  = '0;
            last_d = preset_idx;
            if (preset_idx != last_q) begin
                sess_d = '0;
            end
        end else if (state_q == StRun) begin
            // Every RUN cycle advances the divider, including the one that sees a pause edge.
            if (tick) begin
                div_d = '0;
                if (rem_q == RemOne) begin
                    rem_d  = '0;
                    done_d = 1'b1;
                    sess_d = (sess_q == BcdWrapCode) ? '0 : bcd_inc(sess_q);
                end else begin
                    rem_d = bcd_time_dec(rem_q);
                end
            end else begin
                div_d = div_q + DivW'(1);
            end
        end
`ifdef TIMER_AUTO_RELOAD_EN
        else if (state_q == StDone) begin
            rem_d = preset_bcd[last_q];
            div_d = '0;
        end
`endif
        bcd_time_d  = rem_q;
        bcd_count_d = sess_q;
        dat_vld_d   = (rem_q != bcd_time_q) || (sess_q != bcd_count_q);
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q       <= '0;
            div_q       <= '0;
            sess_q      <= '0;
            last_q      <= '0;
            bcd_time_q  <= '0;
            bcd_count_q <= '0;
            done_q      <= 1'b0;
            dat_vld_q   <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            div_q       <= div_d;
            sess_q      <= sess_d;
            last_q      <= last_d;
            bcd_time_q  <= bcd_time_d;
            bcd_count_q <= bcd_count_d;
            done_q      <= done_d;
            dat_vld_q   <= dat_vld_d;
        end
    end

    // Output decode.
    always_comb begin
        running   = (state_q == StRun);
        bcd_time  = bcd_time_q;
        bcd_count = bcd_count_q;
        done      = done_q;
        dat_vld   = dat_vld_q;
    end

endmodule

// File: tb/tb_multi_preset_timer.sv
// Scoreboard bench for multi_preset_timer with CLK_HZ=10 and presets {5999, 600, 2, 3} s.
module tb_multi_preset_timer;

    localparam int unsigned CLK_HZ     = 10;
    localparam int unsigned N_PRESET   = 4;
    localparam logic [63:0] PRESET_SEC = {16'd5999, 16'd600, 16'd2, 16'd3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  btn = '0;
    logic        pause_btn = 1'b0;
    logic [15:0] bcd_time;
    logic [15:0] bcd_count;
    logic        running;
    logic        done;
    logic        dat_vld;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] t;
        logic [15:0] c;
        int          at;
    } exp_t;

    exp_t vq[$];
    int   dq[$];

    multi_preset_timer #(
        .CLK_HZ     (CLK_HZ),
        .N_PRESET   (N_PRESET),
        .PRESET_SEC (PRESET_SEC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .pause_btn (pause_btn),
        .bcd_time  (bcd_time),
        .bcd_count (bcd_count),
        .running   (running),
        .done      (done),
        .dat_vld   (dat_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk_h(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void chk_d(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void exp_v(logic [15:0] t, logic [15:0] c, int at);
        exp_t e;
        e.t  = t;
        e.c  = c;
        e.at = at;
        vq.push_back(e);
    endfunction

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Called on a negedge; drives the buttons for exactly one clock.
    task automatic pulse(input logic [3:0] b, input logic p, output int c0);
        c0        = cyc;
        btn       = b;
        pause_btn = p;
        @(negedge clk);
        btn       = '0;
        pause_btn = 1'b0;
    endtask

    // Monitor: every dat_vld / done pulse is matched against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   d;
        if (rst_n === 1'b1 && dat_vld === 1'b1) begin
            if (vq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dat_vld_unexpected @cycle %0d: got pulse time=%0h count=%0h want none",
                         cyc, bcd_time, bcd_count);
            end else begin
                e = vq.pop_front();
                chk_h("vld_time", {16'h0, bcd_time}, {16'h0, e.t});
                chk_h("vld_count", {16'h0, bcd_count}, {16'h0, e.c});
                chk_d("vld_cycle", cyc, e.at);
            end
        end
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (dq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected @cycle %0d: got pulse want none", cyc);
            end else begin
                d = dq.pop_front();
                chk_d("done_cycle", cyc, d);
            end
        end
    end

    initial begin : stim
        int c;
        int c2;
        int cf;

        // Reset state
        repeat (3) @(negedge clk);
        chk_h("rst_time", {16'h0, bcd_time}, 32'h0);
        chk_h("rst_count", {16'h0, bcd_count}, 32'h0);
        chk_h("rst_running", {31'h0, running}, 32'h0);
        chk_h("rst_done", {31'h0, done}, 32'h0);
        chk_h("rst_dat_vld", {31'h0, dat_vld}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3 s countdown on preset 0: load 3 edges after press, ticks 10 cycles apart
        pulse(4'b0001, 1'b0, c);
        exp_v(16'h0003, 16'h0000, c + 4);
        exp_v(16'h0002, 16'h0000, c + 14);
        exp_v(16'h0001, 16'h0000, c + 24);
        exp_v(16'h0000, 16'h0001, c + 34);
        dq.push_back(c + 33);
        wait_to(c + 3);
        chk_h("s1_running", {31'h0, running}, 32'h1);
        wait_to(c + 40);
        chk_h("s1_done_state_running", {31'h0, running}, 32'h0);

        // Same preset again, paused for 50 idle cycles after the first decrement
        pulse(4'b0001, 1'b0, c);
        exp_v(16'h0003, 16'h0001, c + 4);
        exp_v(16'h0002, 16'h0001, c + 14);
        wait_to(c + 15);
        pulse(4'b0000, 1'b1, c2);  // pause edge acts at c+18, divider then at 5
        wait_to(c + 40);
        chk_h("pause_time_frozen", {16'h0, bcd_time}, 32'h0002);
        chk_h("pause_running", {31'h0, running}, 32'h0);
        wait_to(c + 66);
        pulse(4'b0000, 1'b1, c2);  // resume edge acts at c+69, 5 more RUN cycles to tick
        exp_v(16'h0001, 16'h0001, c + 75);
        exp_v(16'h0000, 16'h0002, c + 85);
        dq.push_back(c + 84);
        wait_to(c + 90);

        // Different preset clears the count; simultaneous btn[2]+btn[0] picks index 2 (600 s)
        pulse(4'b0010, 1'b0, c);
        exp_v(16'h0002, 16'h0000, c + 4);
        wait_to(c + 6);
        pulse(4'b0101, 1'b0, c2);
        exp_v(16'h1000, 16'h0000, c2 + 4);
        exp_v(16'h0959, 16'h0000, c2 + 14);
        wait_to(c2 + 16);

        // Back to preset 0: count continues from 0000
        pulse(4'b0001, 1'b0, c);
        exp_v(16'h0003, 16'h0000, c + 4);
        exp_v(16'h0002, 16'h0000, c + 14);
        exp_v(16'h0001, 16'h0000, c + 24);
        exp_v(16'h0000, 16'h0001, c + 34);
        dq.push_back(c + 33);
        wait_to(c + 40);

        // Largest preset 5999 s shows 99:59
        pulse(4'b1000, 1'b0, c);
        exp_v(16'h9959, 16'h0000, c + 4);
        exp_v(16'h9958, 16'h0000, c + 14);
        wait_to(c + 16);

        // Preset and pause in the same cycle: preset wins, timer runs
        pulse(4'b0010, 1'b1, c);
        exp_v(16'h0002, 16'h0000, c + 4);
        exp_v(16'h0001, 16'h0000, c + 14);
        exp_v(16'h0000, 16'h0001, c + 24);
        dq.push_back(c + 23);
        wait_to(c + 6);
        chk_h("preset_over_pause_running", {31'h0, running}, 32'h1);
        wait_to(c + 30);

        // Pause in DONE is ignored
        pulse(4'b0000, 1'b1, c);
        wait_to(c + 8);
        chk_h("pause_in_done_running", {31'h0, running}, 32'h0);

        // Session counter at 9999 wraps to 0000 on the next completion
        cf = cyc;
        force dut.sess_q = 16'h9999;
        exp_v(16'h0000, 16'h9999, cf + 1);
        @(negedge clk);
        release dut.sess_q;
        wait_to(cf + 3);
        pulse(4'b0010, 1'b0, c);
        exp_v(16'h0002, 16'h9999, c + 4);
        exp_v(16'h0001, 16'h9999, c + 14);
        exp_v(16'h0000, 16'h0000, c + 24);
        dq.push_back(c + 23);
        wait_to(c + 30);

        // Reset in the middle of a run: everything clears, no completion follows
        pulse(4'b0001, 1'b0, c);
        exp_v(16'h0003, 16'h0000, c + 4);
        exp_v(16'h0002, 16'h0000, c + 14);
        wait_to(c + 20);
        rst_n = 1'b0;
        @(negedge clk);
        chk_h("midrun_rst_time", {16'h0, bcd_time}, 32'h0);
        chk_h("midrun_rst_count", {16'h0, bcd_count}, 32'h0);
        chk_h("midrun_rst_running", {31'h0, running}, 32'h0);
        chk_h("midrun_rst_done", {31'h0, done}, 32'h0);
        chk_h("midrun_rst_dat_vld", {31'h0, dat_vld}, 32'h0);
        rst_n = 1'b1;
        wait_to(c + 60);
        chk_h("after_rst_running", {31'h0, running}, 32'h0);
        chk_h("after_rst_time", {16'h0, bcd_time}, 32'h0);

        // Every expected pulse must have been seen
        chk_d("vld_queue_drained", vq.size(), 0);
        chk_d("done_queue_drained", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_preset_timer.md
MULTI_PRESET_TIMER -- requirements
Module: multi_preset_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 125000000, meaning clk cycles per one-second tick.
REQ-002 SHALL have parameter N_PRESET, default 4, meaning the number of preset buttons, range 1..8.
REQ-003 SHALL have parameter PRESET_SEC, default {16'd3000,16'd1500,16'd600,16'd300}, meaning N_PRESET packed 16-bit durations in seconds, where index i is bits [16i+15:16i].
REQ-004 SHALL have port clk  input  1  system clock; one clock domain only.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port btn  input  N_PRESET  asynchronous preset-select buttons, active-high.
REQ-007 SHALL have port pause_btn  input  1  asynchronous pause/resume button, active-high.
REQ-008 SHALL have port bcd_time  output  16  remaining time as BCD digits M1 M0 S1 S0, with M1 in [15:12].
REQ-009 SHALL have port bcd_count  output  16  completed-session count as 4 BCD digits, with the thousands digit in [15:12].
REQ-010 SHALL have port running  output  1  high while in state RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a session completes.
REQ-012 SHALL have port dat_vld  output  1  one-cycle pulse when bcd_time or bcd_count changes.

Function
REQ-013 SHALL pass every button through a 2-flop synchroniser followed by a rising-edge detector, and only the detected edges SHALL act.
REQ-014 SHALL implement the states IDLE, RUN, PAUSE and DONE.
REQ-015 SHALL, on a preset edge i in any state, load remaining with PRESET_SEC[i], clear the tick divider, and enter RUN.
REQ-016 SHALL, when several preset edges occur in the same cycle, act on the highest index only.
REQ-017 SHALL clear the session counter when the selected preset index differs from the last selected index, and keep it when the index is the same.
REQ-018 SHALL advance the tick divider only in RUN, count it 0..CLK_HZ-1, and assert the tick at CLK_HZ-1, so that the first decrement occurs exactly CLK_HZ cycles after entry into RUN.
REQ-019 SHALL, on a tick in RUN, decrement remaining by 1.
REQ-020 SHALL, on a tick in RUN with remaining==1, set remaining to 0, enter DONE, pulse done, and increment the session counter.
REQ-021 SHALL wrap the session counter from 9999 to 0.
REQ-022 SHALL toggle the state RUN<->PAUSE on a pause edge, with the divider and remaining frozen while in PAUSE.
REQ-023 SHALL ignore a pause edge in IDLE or DONE.
REQ-024 SHALL give a preset edge priority over a pause edge arriving in the same cycle.
REQ-025 SHALL register bcd_time and bcd_count, updated 1 cycle after remaining or the session counter changes.
REQ-026 SHALL encode bcd_time as minutes = remaining/60 and seconds = remaining%60, with each digit in 0..9.
REQ-027 SHALL compute bcd_time without a runtime divider; any incremental or iterative method SHALL still meet the 1-cycle latency of REQ-025.
REQ-028 SHALL pulse dat_vld in the same cycle that bcd_time or bcd_count takes a new value.
REQ-029 SHALL fail elaboration if any PRESET_SEC entry is 0 or greater than 5999 (99:59).

Reset
REQ-030 SHALL, while rst_n==0 at a clk edge, enter IDLE and clear to 0 remaining, the divider, the session counter, the last-selected index, the synchronisers, bcd_time, bcd_count, running, done and dat_vld.
REQ-031 SHALL, on a reset asserted mid-RUN, complete no session and produce no done pulse.

Configuration
REQ-032 SHALL, with macro TIMER_AUTO_RELOAD_EN defined, stay in DONE for exactly one cycle, then reload the last preset, clear the divider, and re-enter RUN.
REQ-033 SHALL, without TIMER_AUTO_RELOAD_EN, remain in DONE until a preset edge or reset occurs.

Structure
REQ-034 SHALL place the state enum, the 4-bit BCD digit type, MAX_SEC=5999 and BCD_WRAP=9999 in the shared package timer_pkg.
REQ-035 SHALL implement the synchroniser and edge detector as sub-module btn_sync_edge, instantiated N_PRESET+1 times.

Verification
REQ-036 SHALL cover this scenario with CLK_HZ=10 and PRESET_SEC[0]=3: a btn[0] pulse -> running=1, bcd_time 0003->0002->0001->0000 at 10-cycle spacing, done pulses once, and bcd_count=0001.
REQ-037 SHALL cover this scenario: during RUN, a pause pulse, 50 idle cycles, then a pause pulse -> bcd_time is unchanged for the 50 cycles and the countdown resumes with no lost cycles.
REQ-038 SHALL cover this scenario: btn[2] and btn[0] rise in the same cycle -> remaining loads PRESET_SEC[2] (600 -> bcd_time 1000).
REQ-039 SHALL cover this scenario: 2 sessions on btn[0], then btn[1] -> bcd_count goes 0002->0000; btn[0] again -> count continues from 0000.
REQ-040 SHALL cover this scenario: the session counter is forced to 9999 and a session completes -> bcd_count=0000 and dat_vld pulses.
REQ-041 SHALL cover this scenario: rst_n driven low mid-RUN for 1 cycle -> state IDLE, all outputs 0, no done pulse; with TIMER_AUTO_RELOAD_EN, completion re-enters RUN 1 cycle after done.
